pool_aer_scheduler: RTL and testbench
=====================================

// Module: pool_aer_scheduler
// PURPOSE
//  Sequences the pooling layer for one timestep: clears the pool inhibition RAM, then round-robin
//  arbitrates N_CH per-channel conv-spike AER FIFOs into the single pooling-layer AER input.
//  Tags each event with its channel in bits [17:16] and pulses a valid strobe toward the pool layer.
//  Paces issue with the pool layer's read-request handshake. Sits between the conv1 output FIFOs and the pool layer.
// PARAMETERS
//  N_CH       4    number of conv channels / FIFOs (1..4; channel tag is 2 bits)
//  ADDR_W     16   conv AER address width ([15:8]=row M, [7:0]=col N)
//  INH_DEPTH  256  inhibition RAM entries cleared per timestep
//  INH_AW     8    inhibition RAM address width
// PORTS
//  work_clk        in   1            clock
//  rst             in   1            asynchronous reset, active-high
//  step_start      in   1            1-cycle pulse: begin timestep
//  conv_done       in   1            level: conv layer has produced all spikes of this timestep
//  fifo_empty      in   N_CH         per-channel FIFO empty flags
//  fifo_dout       in   N_CH*ADDR_W  per-channel FIFO data; channel i at [i*ADDR_W +: ADDR_W]
//  fifo_rd_en      out  N_CH         one-hot read strobe
//  pool_read_req   in   1            pool layer idle/ready (high = may accept an event)
//  pool_aer_data   out  ADDR_W+2     {channel[1:0], address}
//  pool_aer_valid  out  1            1-cycle event strobe to pool layer
//  inh_clr_we      out  1            inhibition RAM clear write enable (data written = 0)
//  inh_clr_addr    out  INH_AW       inhibition RAM clear address
//  busy            out  1            high in every state except S_IDLE
//  step_done       out  1            1-cycle pulse at end of timestep
// BEHAVIOUR
//  Reset: all outputs 0, state S_IDLE, RR pointer = N_CH-1 (channel 0 has first priority), req_seen_low=0.
//  S_IDLE : step_start -> S_CLEAR (addr counter 0). step_start in any other state is ignored.
//  S_CLEAR: inh_clr_we=1, inh_clr_addr=count, count++ each cycle; after INH_DEPTH-1 written -> S_ARB.
//           Exactly INH_DEPTH write cycles; counter wraps to 0, never writes past INH_DEPTH-1.
//  S_ARB  : wait for pool_read_req=1. If any !fifo_empty: grant g = first non-empty channel after pointer
//           (cyclic), fifo_rd_en[g]=1 for exactly one cycle, pointer<=g -> S_READ.
//           Else if conv_done -> S_DONE. Non-empty FIFO wins over conv_done in the same cycle.
//  S_READ : FIFO data valid (1-cycle read latency) -> latch {g[1:0], fifo_dout[g]} -> S_ISSUE.
//  S_ISSUE: pool_aer_valid=1 for one cycle with latched data -> S_WAIT. pool_aer_data holds until next issue.
//  S_WAIT : wait until pool_read_req observed 0 (pool accepted), then -> S_ARB (which re-waits for req=1).
//           Guarantees at most one event in flight; issue-to-issue minimum 4 cycles.
//  S_DONE : step_done=1 for one cycle -> S_IDLE.
//  fifo_rd_en never asserted for an empty FIFO. Unused high bits of channel tag = 0 when N_CH<4.
//  Reset mid-operation: immediate return to S_IDLE; partial clear is abandoned (next step_start re-clears).
//  Latency step_start -> first pool_aer_valid: INH_DEPTH+3 cycles with data waiting and req=1.
// CONFIGURATION
//  SCHED_SPIKE_CNT_EN defined: adds output spike_cnt [N_CH*16]; per-channel 16-bit counters of issued
//   events, +1 on each pool_aer_valid for that channel, saturate at 16'hFFFF, cleared on step_start and rst.
//  Not defined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  Package pool_sched_pkg: state encoding (one-hot: S_IDLE,S_CLEAR,S_ARB,S_READ,S_ISSUE,S_WAIT,S_DONE),
//   AER field positions (CH_MSB=17, CH_LSB=16, M=[15:8], N=[7:0]), CH_W=2.
//  Sub-module rr_arbiter: N_CH request vector + pointer -> one-hot grant and grant index (combinational).
// TESTING
//  1 step_start, all FIFOs empty, conv_done=1 -> 256 clear writes addr 0..255, then step_done pulse, busy falls.
//  2 ch0,ch2 each hold 2 events, req toggles per pool -> issue order ch0,ch2,ch0,ch2; data[17:16]=0,2,0,2.
//  3 Event 16'h0A05 in ch3 -> pool_aer_data=18'h30A05, valid exactly 1 cycle, one fifo_rd_en[3] pulse.
//  4 pool_read_req held 0 after issue -> no further rd_en/valid; release -> next event issued.
//  5 conv_done=1 same cycle ch1 becomes non-empty -> ch1 event issued before step_done.
//  6 rst asserted mid-S_CLEAR at addr 100 -> outputs 0, S_IDLE; next step_start restarts at addr 0.

Source files
------------

// File: rtl/pool_sched_pkg.sv
// Shared definitions for the pooling-layer AER scheduler.
//   - state_t    : one-hot scheduler state encoding
//   - CH_W       : width of the channel tag prepended to each conv AER address
//   - CH_MSB/LSB : channel tag position inside the pooled AER word
//   - aer_evt_t  : field layout of a tagged event {channel, row M, col N}
package pool_sched_pkg;

  localparam int CH_W   = 2;
  localparam int CH_LSB = 16;
  localparam int CH_MSB = CH_LSB + CH_W - 1;

  typedef enum logic [6:0] {
    S_IDLE  = 7'b000_0001,
    S_CLEAR = 7'b000_0010,
    S_ARB   = 7'b000_0100,
    S_READ  = 7'b000_1000,
    S_ISSUE = 7'b001_0000,
    S_WAIT  = 7'b010_0000,
    S_DONE  = 7'b100_0000
  } state_t;

  // Tagged event as seen by the pool layer: [17:16]=channel, [15:8]=M, [7:0]=N.
  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [7:0]      m;
    logic [7:0]      n;
  } aer_evt_t;

endpackage

// File: rtl/pool_aer_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among N_CH requesters.
// Ports:
//   req       in  N_CH   request vector (one bit per channel)
//   ptr       in  CH_W   index of the most recently granted channel
//   grant     out N_CH   one-hot grant (all zero when no request)
//   grant_idx out CH_W   binary index of the granted channel
//   any_req   out 1      at least one request present
module rr_arbiter
  import pool_sched_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant,
  output logic [CH_W-1:0] grant_idx,
  output logic            any_req
);

  int idx;

  // Scan from the farthest candidate (ptr itself) to the nearest (ptr+1);
  // later hits overwrite earlier ones, so the channel right after ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    any_req   = |req;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_CH;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pool_aer_scheduler.sv
// pool_aer_scheduler: per-timestep sequencer for the pooling layer.
// Clears the pool inhibition RAM, then round-robin drains the conv-channel
// AER FIFOs into the pool layer, one event in flight at a time.
// Optional feature macro: SCHED_SPIKE_CNT_EN adds per-channel issued-event
// counters on output spike_cnt.
// Ports:
//   work_clk, rst   clock, asynchronous active-high reset
//   step_start      1-cycle pulse starting a timestep (ignored unless idle)
//   conv_done       conv layer finished producing this timestep's spikes
//   fifo_empty      per-channel FIFO empty flags
//   fifo_dout       per-channel FIFO data, channel i at [i*ADDR_W +: ADDR_W]
//   fifo_rd_en      one-hot FIFO read strobe
//   pool_read_req   pool layer ready for an event
//   pool_aer_data   {channel, address} of the last issued event
//   pool_aer_valid  1-cycle event strobe
//   inh_clr_we      inhibition RAM clear write enable
//   inh_clr_addr    inhibition RAM clear address
//   busy            high whenever not idle
//   step_done       1-cycle end-of-timestep pulse
//   spike_cnt       (SCHED_SPIKE_CNT_EN only) 16-bit saturating count per channel
module pool_aer_scheduler
  import pool_sched_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int ADDR_W    = 16,
  parameter int INH_DEPTH = 256,
  parameter int INH_AW    = 8
) (
  input  logic                     work_clk,
  input  logic                     rst,
  input  logic                     step_start,
  input  logic                     conv_done,
  input  logic [N_CH-1:0]          fifo_empty,
  input  logic [N_CH*ADDR_W-1:0]   fifo_dout,
  output logic [N_CH-1:0]          fifo_rd_en,
  input  logic                     pool_read_req,
  output logic [ADDR_W+1:0]        pool_aer_data,
  output logic                     pool_aer_valid,
  output logic                     inh_clr_we,
  output logic [INH_AW-1:0]        inh_clr_addr,
  output logic                     busy,
  output logic                     step_done
`ifdef SCHED_SPIKE_CNT_EN
  ,
  output logic [N_CH*16-1:0]       spike_cnt
`endif
);

  state_t              state_q, state_d;
  logic [INH_AW-1:0]   cnt_q, cnt_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     gidx_q, gidx_d;
  logic [ADDR_W+1:0]   data_q, data_d;

  logic [N_CH-1:0]     arb_grant;
  logic [CH_W-1:0]     arb_idx;
  logic                arb_any;
  logic [ADDR_W-1:0]   sel_dout;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req       (~fifo_empty),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  // Data of the channel granted in the previous ARB cycle.
  always_comb begin
    sel_dout = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gidx_q == CH_W'(i)) sel_dout = fifo_dout[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ptr_d          = ptr_q;
    gidx_d         = gidx_q;
    data_d         = data_q;
    fifo_rd_en     = '0;
    inh_clr_we     = 1'b0;
    pool_aer_valid = 1'b0;
    step_done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (step_start) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        inh_clr_we = 1'b1;
        if (cnt_q == INH_AW'(INH_DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = S_ARB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ARB: begin
        // Pending events take priority over conv_done so nothing is stranded.
        if (pool_read_req) begin
          if (arb_any) begin
            fifo_rd_en = arb_grant;
            ptr_d      = arb_idx;
            gidx_d     = arb_idx;
            state_d    = S_READ;
          end else if (conv_done) begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        // FIFO output is valid one cycle after the read strobe.
        data_d  = {gidx_d, sel_dout};
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        pool_aer_valid = 1'b1;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        // The pool layer drops its request once it has taken the event.
        if (!pool_read_req) state_d = S_ARB;
      end
      S_DONE: begin
        step_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge work_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= CH_W'(N_CH - 1);
      gidx_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      data_q  <= data_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign inh_clr_addr  = cnt_q;
  assign pool_aer_data = data_q;

`ifdef SCHED_SPIKE_CNT_EN
  logic [N_CH-1:0][15:0] spk_q, spk_d;

  always_comb begin
    spk_d = spk_q;
    if (step_start) begin
      spk_d = '0;
    end else if (state_q == S_ISSUE) begin
      for (int i = 0; i < N_CH; i++) begin
        if (gidx_q == CH_W'(i) && spk_q[i] != 16'hFFFF) spk_d[i] = spk_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge work_clk or posedge rst) begin
    if (rst) spk_q <= '0;
    else     spk_q <= spk_d;
  end

  assign spike_cnt = spk_q;
`endif

endmodule

// File: tb/tb_pool_aer_scheduler.sv
module tb_pool_aer_scheduler;
  import pool_sched_pkg::*;

  localparam int N_CH      = 4;
  localparam int ADDR_W    = 16;
  localparam int INH_DEPTH = 256;
  localparam int INH_AW    = 8;

  logic                   work_clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   step_start = 1'b0;
  logic                   conv_done = 1'b0;
  logic [N_CH-1:0]        fifo_empty = '1;
  logic [N_CH*ADDR_W-1:0] fifo_dout = '0;
  logic [N_CH-1:0]        fifo_rd_en;
  logic                   pool_read_req = 1'b0;
  logic [ADDR_W+1:0]      pool_aer_data;
  logic                   pool_aer_valid;
  logic                   inh_clr_we;
  logic [INH_AW-1:0]      inh_clr_addr;
  logic                   busy;
  logic                   step_done;
`ifdef SCHED_SPIKE_CNT_EN
  logic [N_CH*16-1:0]     spike_cnt;
`endif

  pool_aer_scheduler #(.N_CH(N_CH), .ADDR_W(ADDR_W), .INH_DEPTH(INH_DEPTH), .INH_AW(INH_AW)) dut (
    .work_clk(work_clk), .rst(rst), .step_start(step_start), .conv_done(conv_done),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
    .pool_read_req(pool_read_req), .pool_aer_data(pool_aer_data), .pool_aer_valid(pool_aer_valid),
    .inh_clr_we(inh_clr_we), .inh_clr_addr(inh_clr_addr), .busy(busy), .step_done(step_done)
`ifdef SCHED_SPIKE_CNT_EN
    , .spike_cnt(spike_cnt)
`endif
  );

  always #5 work_clk = ~work_clk;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;

  logic [ADDR_W-1:0] fq [N_CH][$];   // contents of the FIFOs feeding the DUT
  logic [ADDR_W-1:0] mq [N_CH][$];   // reference copy consumed by the model
  int                m_ptr = N_CH - 1;
  logic [ADDR_W+1:0] expq [$];
  logic [N_CH-1:0]   rd_pend = '0;

  logic [ADDR_W+1:0] obs [$];
  int unsigned       obs_cyc [$];
  int unsigned       clr_cnt, clr_err, clr_next, valid_long, rd_bad, done_cnt, done_long, done_cyc;
  int unsigned       rd_cnt [N_CH];
  bit                prev_valid = 0, prev_done = 0, auto_pool = 0;

  always @(posedge work_clk) cyc++;

  // FIFO model: one-cycle read latency.
  always @(posedge work_clk) begin
    for (int i = 0; i < N_CH; i++)
      if (rd_pend[i] && fq[i].size() > 0) fifo_dout[i*ADDR_W +: ADDR_W] <= fq[i].pop_front();
  end

  // Output monitor, FIFO flag update, read strobe sampling late in the cycle.
  always @(negedge work_clk) begin
    if (pool_aer_valid) begin
      obs.push_back(pool_aer_data);
      obs_cyc.push_back(cyc);
      if (prev_valid) valid_long++;
    end
    prev_valid = pool_aer_valid;
    if (inh_clr_we) begin
      if (inh_clr_addr != INH_AW'(clr_next)) clr_err++;
      clr_next++;
      clr_cnt++;
    end
    if (step_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (prev_done) done_long++;
    end
    prev_done = step_done;
    for (int i = 0; i < N_CH; i++) fifo_empty[i] = (fq[i].size() == 0);
    #4;
    rd_pend = fifo_rd_en;
    if ($countones(fifo_rd_en) > 1) rd_bad++;
    for (int i = 0; i < N_CH; i++)
      if (fifo_rd_en[i]) begin
        rd_cnt[i]++;
        if (fifo_empty[i]) rd_bad++;
      end
  end

  // Pool layer model: after accepting an event, drop request for 1..3 cycles.
  initial forever begin
    @(negedge work_clk);
    if (auto_pool && pool_aer_valid) begin
      @(posedge work_clk); #1 pool_read_req = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge work_clk);
      #1 pool_read_req = 1'b1;
    end
  end

  task automatic clear_counters();
    obs.delete(); obs_cyc.delete();
    clr_cnt = 0; clr_err = 0; clr_next = 0; valid_long = 0; rd_bad = 0;
    done_cnt = 0; done_long = 0; done_cyc = 0;
    for (int i = 0; i < N_CH; i++) rd_cnt[i] = 0;
  endtask

  task automatic push_ev(input int ch, input logic [ADDR_W-1:0] v);
    fq[ch].push_back(v);
    mq[ch].push_back(v);
  endtask

  // Reference: each grant goes to the first non-empty channel after the last grant.
  task automatic model_step();
    int g;
    expq.delete();
    forever begin
      g = -1;
      for (int k = 1; k <= N_CH; k++) begin
        int c = (m_ptr + k) % N_CH;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      if (g < 0) break;
      m_ptr = g;
      expq.push_back({2'(g), mq[g].pop_front()});
    end
  endtask

  task automatic pulse_start(output int unsigned t0);
    @(posedge work_clk); #1 step_start = 1'b1; t0 = cyc;
    @(posedge work_clk); #1 step_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge work_clk); #1;
      if (done_cnt > 0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step_start = 0; conv_done = 0; pool_read_req = 0;
    repeat (3) @(posedge work_clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (step_done !== 1'b0) begin failures++; $display("FAIL reset_step_done: got %0b want 0", step_done); end
    checks++; if (pool_aer_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", pool_aer_valid); end
    checks++; if (fifo_rd_en !== '0) begin failures++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    checks++; if (inh_clr_we !== 1'b0) begin failures++; $display("FAIL reset_clr_we: got %0b want 0", inh_clr_we); end
    checks++; if (inh_clr_addr !== '0) begin failures++; $display("FAIL reset_clr_addr: got %0d want 0", inh_clr_addr); end
    checks++; if (pool_aer_data !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", pool_aer_data); end
    rst = 1'b0;
    m_ptr = N_CH - 1;
  endtask

  task automatic test_clear_all_empty();
    int unsigned t0, t1;
    bit ok;
    clear_counters();
    auto_pool = 1; pool_read_req = 1; conv_done = 1;
    pulse_start(t0);
    repeat (50) @(posedge work_clk);
    pulse_start(t1);   // must be ignored while busy
    wait_done(1000, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL clr_done_seen: got %0b want 1", ok); end
    checks++; if (clr_cnt != INH_DEPTH) begin failures++; $display("FAIL clr_count: got %0d want %0d", clr_cnt, INH_DEPTH); end
    checks++; if (clr_err != 0) begin failures++; $display("FAIL clr_addr_seq: got %0d bad addrs want 0", clr_err); end
    checks++; if (obs.size() != 0) begin failures++; $display("FAIL clr_no_events: got %0d want 0", obs.size()); end
    repeat (2) @(negedge work_clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clr_busy_fall: got %0b want 0", busy); end
    checks++; if (done_cnt != 1 || done_long != 0) begin failures++; $display("FAIL clr_done_pulse: got %0d/%0d want 1/0", done_cnt, done_long); end
  endtask

  task automatic test_rr_two_ch();
    int unsigned t0;
    bit ok;
    int exp_tag [4] = '{0, 2, 0, 2};
    clear_counters();
    auto_pool = 1; pool_read_req = 1; conv_done = 1;
    for (int i = 0; i < 2; i++) begin
      push_ev(0, 16'($urandom));
      push_ev(2, 16'($urandom));
    end
    pulse_start(t0);
    wait_done(2000, ok);
    model_step();
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rr_done_seen: got %0b want 1", ok); end
    checks++; if (obs.size() != expq.size()) begin failures++; $display("FAIL rr_count: got %0d want %0d", obs.size(), expq.size()); end
    for (int i = 0; i < obs.size() && i < 4; i++) begin
      checks++; if (obs[i][CH_MSB:CH_LSB] != 2'(exp_tag[i])) begin failures++; $display("FAIL rr_tag%0d: got %0d want %0d", i, obs[i][CH_MSB:CH_LSB], exp_tag[i]); end
      if (i < expq.size()) begin
        checks++; if (obs[i] !== expq[i]) begin failures++; $display("FAIL rr_data%0d: got %h want %h", i, obs[i], expq[i]); end
      end
      if (i > 0) begin
        checks++; if (obs_cyc[i] - obs_cyc[i-1] < 4) begin failures++; $display("FAIL rr_spacing%0d: got %0d want >=4", i, obs_cyc[i] - obs_cyc[i-1]); end
      end
    end
    checks++; if (rd_bad != 0) begin failures++; $display("FAIL rr_rd_legal: got %0d bad strobes want 0", rd_bad); end
  endtask

  task automatic test_single_ch3();
    int unsigned t0;
    bit ok;
    clear_counters();
    auto_pool = 1; pool_read_req = 1; conv_done = 1;
    push_ev(3, 16'h0A05);
    pulse_start(t0);
    wait_done(1000, ok);
    model_step();
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ch3_done_seen: got %0b want 1", ok); end
    checks++; if (obs.size() != 1) begin failures++; $display("FAIL ch3_count: got %0d want 1", obs.size()); end
    if (obs.size() >= 1) begin
      checks++; if (obs[0] !== 18'h30A05) begin failures++; $display("FAIL ch3_data: got %h want 30a05", obs[0]); end
      checks++; if (obs_cyc[0] - t0 != INH_DEPTH + 3) begin failures++; $display("FAIL ch3_latency: got %0d want %0d", obs_cyc[0] - t0, INH_DEPTH + 3); end
    end
    checks++; if (valid_long != 0) begin failures++; $display("FAIL ch3_valid_width: got %0d long pulses want 0", valid_long); end
    checks++; if (rd_cnt[3] != 1) begin failures++; $display("FAIL ch3_rd_pulses: got %0d want 1", rd_cnt[3]); end
    checks++; if (rd_cnt[0] + rd_cnt[1] + rd_cnt[2] != 0) begin failures++; $display("FAIL ch3_other_rd: got %0d want 0", rd_cnt[0] + rd_cnt[1] + rd_cnt[2]); end
  endtask

  task automatic test_backpressure();
    int unsigned t0, rd_before;
    bit ok;
    clear_counters();
    auto_pool = 0; pool_read_req = 1; conv_done = 0;
    push_ev(1, 16'($urandom));
    push_ev(1, 16'($urandom));
    model_step();
    pulse_start(t0);
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin @(negedge work_clk); #1; ok = (obs.size() >= 1); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_first_issue: got %0b want 1", ok); end
    @(posedge work_clk); #1 pool_read_req = 0;
    rd_before = rd_cnt[1];
    repeat (30) @(posedge work_clk);
    #1;
    checks++; if (obs.size() != 1) begin failures++; $display("FAIL bp_hold_valid: got %0d events want 1", obs.size()); end
    checks++; if (rd_cnt[1] != rd_before) begin failures++; $display("FAIL bp_hold_rd: got %0d want %0d", rd_cnt[1], rd_before); end
    pool_read_req = 1;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin @(negedge work_clk); #1; ok = (obs.size() >= 2); end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_release_issue: got %0b want 1", ok); end
    @(posedge work_clk); #1 pool_read_req = 0; conv_done = 1;
    @(posedge work_clk); #1 pool_read_req = 1;
    wait_done(100, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL bp_done_seen: got %0b want 1", ok); end
    for (int i = 0; i < 2 && i < obs.size(); i++) begin
      checks++; if (obs[i] !== expq[i]) begin failures++; $display("FAIL bp_data%0d: got %h want %h", i, obs[i], expq[i]); end
    end
    auto_pool = 1;
  endtask

  task automatic test_done_race();
    int unsigned t0;
    bit ok;
    clear_counters();
    auto_pool = 1; pool_read_req = 1; conv_done = 0;
    pulse_start(t0);
    repeat (INH_DEPTH + 10) @(posedge work_clk);
    #1;
    push_ev(1, 16'($urandom));
    conv_done = 1;
    wait_done(200, ok);
    model_step();
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL race_done_seen: got %0b want 1", ok); end
    checks++; if (obs.size() != 1) begin failures++; $display("FAIL race_count: got %0d want 1", obs.size()); end
    if (obs.size() >= 1 && expq.size() >= 1) begin
      checks++; if (obs[0] !== expq[0]) begin failures++; $display("FAIL race_data: got %h want %h", obs[0], expq[0]); end
      checks++; if (!(obs_cyc[0] < done_cyc)) begin failures++; $display("FAIL race_order: issue at %0d done at %0d want issue first", obs_cyc[0], done_cyc); end
    end
  endtask

  task automatic test_random();
    int unsigned t0;
    bit ok;
    for (int r = 0; r < 4; r++) begin
      clear_counters();
      auto_pool = 1; pool_read_req = 1; conv_done = 1;
      for (int c = 0; c < N_CH; c++)
        repeat ($urandom_range(0, 3)) push_ev(c, 16'($urandom));
      pulse_start(t0);
      wait_done(3000, ok);
      model_step();
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rand%0d_done_seen: got %0b want 1", r, ok); end
      checks++; if (obs.size() != expq.size()) begin failures++; $display("FAIL rand%0d_count: got %0d want %0d", r, obs.size(), expq.size()); end
      for (int i = 0; i < obs.size() && i < expq.size(); i++) begin
        checks++; if (obs[i] !== expq[i]) begin failures++; $display("FAIL rand%0d_ev%0d: got %h want %h", r, i, obs[i], expq[i]); end
      end
      checks++; if (rd_bad != 0 || valid_long != 0) begin failures++; $display("FAIL rand%0d_strobes: got %0d/%0d want 0/0", r, rd_bad, valid_long); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int unsigned t0;
    bit ok;
    clear_counters();
    auto_pool = 1; pool_read_req = 1; conv_done = 1;
    pulse_start(t0);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge work_clk);
      ok = (inh_clr_we === 1'b1 && inh_clr_addr == 8'd100);
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mid_reach_100: got %0b want 1", ok); end
    #1 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %0b want 0", busy); end
    checks++; if (inh_clr_we !== 1'b0) begin failures++; $display("FAIL mid_clr_we: got %0b want 0", inh_clr_we); end
    checks++; if (inh_clr_addr !== '0) begin failures++; $display("FAIL mid_clr_addr: got %0d want 0", inh_clr_addr); end
    @(posedge work_clk); #1 rst = 1'b0;
    m_ptr = N_CH - 1;
    clear_counters();
    pulse_start(t0);
    wait_done(1000, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL mid_restart_done: got %0b want 1", ok); end
    checks++; if (clr_cnt != INH_DEPTH || clr_err != 0) begin failures++; $display("FAIL mid_restart_clear: got %0d writes %0d bad want %0d/0", clr_cnt, clr_err, INH_DEPTH); end
  endtask

  initial begin
    clear_counters();
    test_reset();
    test_clear_all_empty();
    test_rr_two_ch();
    test_single_ch3();
    test_backpressure();
    test_done_race();
    test_random();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
